// File: rtl/tcp_tx_scheduler_pkg.sv
// ============================================================================
// tcp_tx_scheduler_pkg : shared FSM states, TX status codes, field offsets
// Rev 1.0
// ============================================================================
`default_nettype none

package tcp_tx_scheduler_pkg;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_META   = 3'd1;
    localparam logic [2:0] c_ST_STATUS = 3'd2;
    localparam logic [2:0] c_ST_DATA   = 3'd3;
    localparam logic [2:0] c_ST_DROP   = 3'd4;
    localparam logic [2:0] c_ST_WAIT   = 3'd5;

    localparam logic [1:0] c_STAT_OK      = 2'd0;
    localparam logic [1:0] c_STAT_NOCONN  = 2'd1;
    localparam logic [1:0] c_STAT_NOSPACE = 2'd2;
    localparam logic [1:0] c_STAT_ERR     = 2'd3;

    localparam int c_META_W           = 32;
    localparam int c_META_SESSION_LSB = 0;
    localparam int c_META_LENGTH_LSB  = 16;
    localparam int c_META_FIELD_W     = 16;
    localparam int c_STATUS_CODE_LSB  = 62;
    localparam int c_DATA_W           = 512;
    localparam int c_KEEP_W           = 64;

endpackage

`default_nettype wire

// File: rtl/tcp_tx_scheduler_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin grant, search starts one past the last grant
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_idx       = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = IDX_W'((int'(last_grant) + i) % N_REQ);
            if (!grant_valid && req[w_idx]) begin
                grant_valid  = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tcp_tx_scheduler.sv
// ============================================================================
// tcp_tx_scheduler : arbitrates N requesters onto one TCP TX meta/status/data
// Rev 1.0
// ============================================================================
`default_nettype none

module tcp_tx_scheduler
    import tcp_tx_scheduler_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int RETRY_WAIT = 64,
    parameter int MAX_RETRY  = 8
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic [N_REQ-1:0]             req_meta_valid,
    output logic [N_REQ-1:0]             req_meta_ready,
    input  logic [32*N_REQ-1:0]          req_meta_data,
    input  logic [N_REQ-1:0]             req_data_valid,
    output logic [N_REQ-1:0]             req_data_ready,
    input  logic [512*N_REQ-1:0]         req_data_tdata,
    input  logic [N_REQ-1:0]             req_data_tlast,
    output logic                         m_axis_tx_metadata_TVALID,
    input  logic                         m_axis_tx_metadata_TREADY,
    output logic [31:0]                  m_axis_tx_metadata_TDATA,
    input  logic                         s_axis_tx_status_TVALID,
    output logic                         s_axis_tx_status_TREADY,
    input  logic [63:0]                  s_axis_tx_status_TDATA,
    output logic                         m_axis_tx_data_TVALID,
    input  logic                         m_axis_tx_data_TREADY,
    output logic [511:0]                 m_axis_tx_data_TDATA,
    output logic [63:0]                  m_axis_tx_data_TKEEP,
    output logic                         m_axis_tx_data_TLAST,
    output logic [31:0]                  sent_count,
    output logic [31:0]                  drop_count
);

    localparam int c_IDX_W   = $clog2(N_REQ);
    localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int c_WAIT_W  = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;

    logic [2:0]           r_state;
    logic [c_IDX_W-1:0]   r_grant;
    logic [N_REQ-1:0]     r_grant_oh;
    logic [c_IDX_W-1:0]   r_last_grant;
    logic [c_META_W-1:0]  r_meta;
    logic [c_RETRY_W-1:0] r_retry_cnt;
    logic [c_WAIT_W-1:0]  r_wait_cnt;
    logic [31:0]          r_sent_count;
    logic [31:0]          r_drop_count;

    logic [N_REQ-1:0]     w_arb_grant;
    logic [c_IDX_W-1:0]   w_arb_idx;
    logic                 w_arb_valid;
    logic [1:0]           w_status_code;
    logic                 w_status_fire;
    logic                 w_retry_ok;
    logic                 w_meta_release;
    logic                 w_beat_valid;
    logic                 w_beat_last;
    logic                 w_pkt_done;
    logic                 w_status_unused;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_rr_arbiter (
        .req         (req_meta_valid),
        .last_grant  (r_last_grant),
        .grant       (w_arb_grant),
        .grant_idx   (w_arb_idx),
        .grant_valid (w_arb_valid)
    );

    assign w_status_code   = s_axis_tx_status_TDATA[c_STATUS_CODE_LSB +: 2];
    assign w_status_unused = ^s_axis_tx_status_TDATA[c_STATUS_CODE_LSB-1:0];
    assign w_status_fire   = (r_state == c_ST_STATUS) && s_axis_tx_status_TVALID;
    assign w_retry_ok      = r_retry_cnt < c_RETRY_W'(MAX_RETRY);
    // Requester meta is released on any final verdict; only a retryable no-space keeps it.
    assign w_meta_release  = w_status_fire && !((w_status_code == c_STAT_NOSPACE) && w_retry_ok);
    assign w_beat_valid    = req_data_valid[r_grant];
    assign w_beat_last     = req_data_tlast[r_grant];
    assign w_pkt_done      = w_beat_valid && w_beat_last &&
                             (((r_state == c_ST_DATA) && m_axis_tx_data_TREADY) ||
                              (r_state == c_ST_DROP));

    assign m_axis_tx_metadata_TVALID = (r_state == c_ST_META);
    assign m_axis_tx_metadata_TDATA  = r_meta;
    assign s_axis_tx_status_TREADY   = (r_state == c_ST_STATUS);
    assign m_axis_tx_data_TKEEP      = '1;
    assign sent_count                = r_sent_count;
    assign drop_count                = r_drop_count;

    // Data path is a pure mux while streaming: zero latency, ready passes straight back.
    always_comb begin
        req_meta_ready        = w_meta_release ? r_grant_oh : '0;
        req_data_ready        = '0;
        m_axis_tx_data_TVALID = 1'b0;
        m_axis_tx_data_TDATA  = '0;
        m_axis_tx_data_TLAST  = 1'b0;
        if (r_state == c_ST_DATA) begin
            req_data_ready        = r_grant_oh & {N_REQ{m_axis_tx_data_TREADY}};
            m_axis_tx_data_TVALID = w_beat_valid;
            m_axis_tx_data_TDATA  = req_data_tdata[int'(r_grant) * c_DATA_W +: c_DATA_W];
            m_axis_tx_data_TLAST  = w_beat_last;
        end else if (r_state == c_ST_DROP) begin
            req_data_ready = r_grant_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= '0;
            r_grant_oh   <= '0;
            r_last_grant <= c_IDX_W'(N_REQ - 1);
            r_meta       <= '0;
            r_retry_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_sent_count <= '0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant     <= w_arb_idx;
                        r_grant_oh  <= w_arb_grant;
                        r_meta      <= req_meta_data[int'(w_arb_idx) * c_META_W +: c_META_W];
                        r_retry_cnt <= '0;
                        r_state     <= c_ST_META;
                    end
                end
                c_ST_META: begin
                    if (m_axis_tx_metadata_TREADY) r_state <= c_ST_STATUS;
                end
                c_ST_STATUS: begin
                    if (w_meta_release) begin
                        r_state <= (w_status_code == c_STAT_OK) ? c_ST_DATA : c_ST_DROP;
                    end else if (w_status_fire) begin
                        r_retry_cnt <= r_retry_cnt + 1'b1;
                        r_wait_cnt  <= '0;
                        r_state     <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (r_wait_cnt == c_WAIT_W'(RETRY_WAIT - 1)) r_state <= c_ST_META;
                    else r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                c_ST_DATA: begin
                    if (w_pkt_done) begin
                        r_sent_count <= r_sent_count + 32'd1;
                        r_last_grant <= r_grant;
                        r_state      <= c_ST_IDLE;
                    end
                end
                c_ST_DROP: begin
                    if (w_pkt_done) begin
                        r_drop_count <= r_drop_count + 32'd1;
                        r_last_grant <= r_grant;
                        r_state      <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tcp_tx_scheduler.sv
// ============================================================================
// tb_tcp_tx_scheduler : directed bench with a cycle-level requester/TX model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tcp_tx_scheduler;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            aresetn;
    logic [N-1:0]    req_meta_valid, req_meta_ready;
    logic [32*N-1:0] req_meta_data;
    logic [N-1:0]    req_data_valid, req_data_ready, req_data_tlast;
    logic [512*N-1:0] req_data_tdata;
    logic            meta_tvalid, meta_tready;
    logic [31:0]     meta_tdata;
    logic            st_tvalid, st_tready;
    logic [63:0]     st_tdata;
    logic            tx_tvalid, tx_tready, tx_tlast;
    logic [511:0]    tx_tdata;
    logic [63:0]     tx_tkeep;
    logic [31:0]     sent_count, drop_count;

    always #5 clk = ~clk;

    tcp_tx_scheduler #(
        .N_REQ      (N),
        .RETRY_WAIT (4),
        .MAX_RETRY  (8)
    ) dut (
        .clk                       (clk),
        .aresetn                   (aresetn),
        .req_meta_valid            (req_meta_valid),
        .req_meta_ready            (req_meta_ready),
        .req_meta_data             (req_meta_data),
        .req_data_valid            (req_data_valid),
        .req_data_ready            (req_data_ready),
        .req_data_tdata            (req_data_tdata),
        .req_data_tlast            (req_data_tlast),
        .m_axis_tx_metadata_TVALID (meta_tvalid),
        .m_axis_tx_metadata_TREADY (meta_tready),
        .m_axis_tx_metadata_TDATA  (meta_tdata),
        .s_axis_tx_status_TVALID   (st_tvalid),
        .s_axis_tx_status_TREADY   (st_tready),
        .s_axis_tx_status_TDATA    (st_tdata),
        .m_axis_tx_data_TVALID     (tx_tvalid),
        .m_axis_tx_data_TREADY     (tx_tready),
        .m_axis_tx_data_TDATA      (tx_tdata),
        .m_axis_tx_data_TKEEP      (tx_tkeep),
        .m_axis_tx_data_TLAST      (tx_tlast),
        .sent_count                (sent_count),
        .drop_count                (drop_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int sess[N], beats[N], left[N], pidx[N], beat[N], used[N];
    bit toggle_rdy;
    logic [1:0]  st_q[$];
    int          meta_cyc[$];
    logic [15:0] meta_sess[$];
    logic [31:0] tx_word[$];
    logic        tx_last[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input int i);
        logic [15:0] s;
        s = 16'(sess[i] + pidx[i]);
        req_meta_data[i*32 +: 32]    = {16'(beats[i] * 64), s};
        req_data_tdata[i*512 +: 512] = {480'd0, s, 16'(beat[i])};
        req_data_tlast[i]            = (beat[i] == beats[i] - 1);
    endtask

    task automatic add_req(input int i, input int s, input int b, input int n);
        sess[i] = s; beats[i] = b; left[i] = n; pidx[i] = 0; beat[i] = 0;
        req_meta_valid[i] = 1'b1;
        req_data_valid[i] = 1'b1;
        drive_req(i);
    endtask

    task automatic clear_logs();
        meta_cyc.delete(); meta_sess.delete(); tx_word.delete(); tx_last.delete();
        for (int i = 0; i < N; i++) used[i] = 0;
    endtask

    task automatic clear_model();
        req_meta_valid = '0; req_data_valid = '0; req_data_tlast = '0;
        req_meta_data = '0; req_data_tdata = '0;
        st_tvalid = 1'b0; st_tdata = '0; st_q.delete();
        meta_tready = 1'b1; tx_tready = 1'b1; toggle_rdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            sess[i] = 0; beats[i] = 1; left[i] = 0; pidx[i] = 0; beat[i] = 0;
        end
        clear_logs();
    endtask

    // Handshakes are decided at the falling edge and applied just after the rising edge.
    task automatic tick();
        logic mh, sh, dh;
        logic [N-1:0] mr, dr;
        logic [1:0] code;
        @(negedge clk);
        mh = meta_tvalid && meta_tready;
        sh = st_tvalid && st_tready;
        dh = tx_tvalid && tx_tready;
        mr = req_meta_ready & req_meta_valid;
        dr = req_data_ready & req_data_valid;
        if (mh) begin meta_cyc.push_back(cyc); meta_sess.push_back(meta_tdata[15:0]); end
        if (dh) begin tx_word.push_back(tx_tdata[31:0]); tx_last.push_back(tx_tlast); end
        @(posedge clk);
        #1;
        cyc++;
        if (sh) st_tvalid = 1'b0;
        if (mh) begin
            if (st_q.size() > 0) code = st_q.pop_front();
            else code = 2'd0;
            st_tvalid = 1'b1;
            st_tdata  = {code, 62'd0};
        end
        for (int i = 0; i < N; i++) begin
            if (mr[i]) req_meta_valid[i] = 1'b0;
            if (dr[i]) begin
                used[i]++;
                if (beat[i] == beats[i] - 1) begin
                    left[i]--; pidx[i]++; beat[i] = 0;
                    req_data_valid[i] = (left[i] > 0);
                    req_meta_valid[i] = (left[i] > 0);
                end else begin
                    beat[i]++;
                end
                drive_req(i);
            end
        end
        if (toggle_rdy) tx_tready = ~tx_tready;
    endtask

    task automatic wait_counts(input string tag, input int es, input int ed, input int budget);
        int n;
        n = 0;
        while ((sent_count != 32'(es) || drop_count != 32'(ed)) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
        tick(); tick();
        chk({tag, "_sent"}, sent_count, 64'(es));
        chk({tag, "_drop"}, drop_count, 64'(ed));
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_model();
        tick(); tick();
        aresetn = 1'b1;
    endtask

    initial begin
        logic [5:0]  lv;
        logic [31:0] w;
        int n;
        aresetn = 1'b0;
        clear_model();

        // Reset state
        do_reset();
        chk("rst_ctrl", {meta_tvalid, st_tready, tx_tvalid, tx_tlast, req_meta_ready, req_data_ready}, 0);
        chk("rst_meta_tdata", meta_tdata, 0);
        chk("rst_sent", sent_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("tkeep", tx_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);

        // Requesters 0 and 2, three beats each, both ok
        add_req(0, 16'h0100, 3, 1);
        add_req(2, 16'h0200, 3, 1);
        wait_counts("two_pkt", 2, 0, 100);
        chk("two_pkt_beats", tx_word.size(), 6);
        chk("two_pkt_meta0", meta_sess.size() > 0 ? meta_sess[0] : 16'hFFFF, 16'h0100);
        chk("two_pkt_meta1", meta_sess.size() > 1 ? meta_sess[1] : 16'hFFFF, 16'h0200);
        lv = '0;
        for (int k = 0; k < 6 && k < tx_last.size(); k++) lv[k] = tx_last[k];
        chk("two_pkt_tlast", lv, 6'b100100);
        for (int k = 0; k < 6; k++) begin
            w = (k < tx_word.size()) ? tx_word[k] : 32'hDEAD_BEEF;
            chk($sformatf("two_pkt_beat%0d", k), w,
                (k < 3) ? {16'h0100, 16'(k)} : {16'h0200, 16'(k - 3)});
        end

        // All four requesting continuously, single-beat packets, from a fresh reset
        do_reset();
        for (int i = 0; i < N; i++) add_req(i, 16'h1100 + i * 16'h0100, 1, 2);
        wait_counts("rr", 8, 0, 200);
        for (int k = 0; k < 8; k++)
            chk($sformatf("rr_order%0d", k), k < meta_sess.size() ? meta_sess[k] : 16'hFFFF,
                16'h1100 + (k % 4) * 16'h0100 + k / 4);
        n = 0;
        foreach (tx_last[k]) n += int'(tx_last[k]);
        chk("rr_single_beat_tlast", n, 8);

        // No-connection on session 0x0005: packet drained and dropped, next requester served
        clear_logs();
        add_req(0, 16'h0005, 4, 1);
        add_req(1, 16'h0300, 1, 1);
        st_q.push_back(2'd1);
        wait_counts("noconn", 9, 1, 100);
        chk("noconn_consumed", used[0], 4);
        chk("noconn_meta0", meta_sess.size() > 0 ? meta_sess[0] : 16'hFFFF, 16'h0005);
        chk("noconn_meta1", meta_sess.size() > 1 ? meta_sess[1] : 16'hFFFF, 16'h0300);
        chk("noconn_tx_beats", tx_word.size(), 1);
        chk("noconn_tx_word", tx_word.size() > 0 ? tx_word[0] : 32'hDEAD_BEEF, 32'h0300_0000);

        // No-space twice then ok: three metadata issues, each 1 META + 1 STATUS + 4 WAIT apart
        clear_logs();
        add_req(2, 16'h0400, 2, 1);
        st_q.push_back(2'd2); st_q.push_back(2'd2); st_q.push_back(2'd0);
        wait_counts("retry", 10, 1, 200);
        chk("retry_meta_issues", meta_cyc.size(), 3);
        chk("retry_gap0", meta_cyc.size() > 1 ? meta_cyc[1] - meta_cyc[0] : 0, 6);
        chk("retry_gap1", meta_cyc.size() > 2 ? meta_cyc[2] - meta_cyc[1] : 0, 6);
        chk("retry_tx_beats", tx_word.size(), 2);

        // No-space nine times: retries exhausted, packet dropped
        clear_logs();
        add_req(3, 16'h0500, 2, 1);
        for (int k = 0; k < 9; k++) st_q.push_back(2'd2);
        wait_counts("exhaust", 10, 2, 400);
        chk("exhaust_meta_issues", meta_cyc.size(), 9);
        chk("exhaust_tx_beats", tx_word.size(), 0);
        chk("exhaust_consumed", used[3], 2);

        // Toggling TX ready, reset lands on beat 2 of requester 2's packet
        clear_logs();
        toggle_rdy = 1'b1;
        add_req(1, 16'h0600, 1, 1);
        add_req(2, 16'h0610, 4, 1);
        n = 0;
        while (tx_word.size() < 2 && n < 100) begin tick(); n++; end
        chk("mid_rst_reach", 64'(n < 100), 64'd1);
        aresetn = 1'b0;
        tick();
        chk("mid_rst_ctrl", {meta_tvalid, st_tready, tx_tvalid, tx_tlast, req_meta_ready, req_data_ready}, 0);
        chk("mid_rst_meta_tdata", meta_tdata, 0);
        chk("mid_rst_sent", sent_count, 0);
        chk("mid_rst_drop", drop_count, 0);
        aresetn = 1'b1;
        clear_model();
        add_req(2, 16'h0810, 1, 1);
        add_req(0, 16'h0800, 1, 1);
        wait_counts("post_rst", 2, 0, 100);
        chk("post_rst_grant0", meta_sess.size() > 0 ? meta_sess[0] : 16'hFFFF, 16'h0800);
        chk("post_rst_grant1", meta_sess.size() > 1 ? meta_sess[1] : 16'hFFFF, 16'h0810);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/tcp_tx_scheduler.md
TCP_TX_SCHEDULER -- requirements
Module: tcp_tx_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters; legal range 2..8.
REQ-002 SHALL have parameter RETRY_WAIT, default 64: idle cycles before re-issuing metadata after a no-space status.
REQ-003 SHALL have parameter MAX_RETRY, default 8: no-space retries allowed before the packet is dropped.
REQ-004 SHALL have these ports: clk  in  1  clock; aresetn  in  1  synchronous active-low reset.
REQ-005 SHALL have these requester metadata ports: req_meta_valid  in  N_REQ; req_meta_ready  out  N_REQ; req_meta_data  in  32*N_REQ, formatted as {length[15:0], session[15:0]} per requester.
REQ-006 SHALL have these requester data ports: req_data_valid  in  N_REQ; req_data_ready  out  N_REQ; req_data_tdata  in  512*N_REQ; req_data_tlast  in  N_REQ.
REQ-007 SHALL have these TX metadata ports: m_axis_tx_metadata_TVALID  out  1; m_axis_tx_metadata_TREADY  in  1; m_axis_tx_metadata_TDATA  out  32, formatted as {length, session}.
REQ-008 SHALL have these TX status ports: s_axis_tx_status_TVALID  in  1; s_axis_tx_status_TREADY  out  1; s_axis_tx_status_TDATA  in  64, where bits [63:62] are 0=ok, 1=no connection, 2=no space, 3=error.
REQ-009 SHALL have these TX data ports: m_axis_tx_data_TVALID  out  1; m_axis_tx_data_TREADY  in  1; m_axis_tx_data_TDATA  out  512; m_axis_tx_data_TKEEP  out  64, all ones; m_axis_tx_data_TLAST  out  1.
REQ-010 SHALL have these counter ports: sent_count  out  32, packets forwarded; drop_count  out  32, packets discarded.

Function
REQ-011 SHALL implement a five-state FSM: IDLE, META, STATUS, DATA, DROP, plus a WAIT state for retry back-off.
REQ-012 IDLE SHALL grant the lowest-index requester with req_meta_valid=1 at or after index last_grant+1 (mod N_REQ), then go to META on the next cycle.
REQ-013 META SHALL drive m_axis_tx_metadata_TVALID=1 with the granted requester's meta, hold TDATA stable until TREADY=1, then go to STATUS.
REQ-014 s_axis_tx_status_TREADY SHALL be 1 only in STATUS, and status words arriving in any other state SHALL stall.
REQ-015 In STATUS, status 0 SHALL pulse req_meta_ready[g] for one cycle and go to DATA.
REQ-016 In STATUS, status 1 or 3 SHALL pulse req_meta_ready[g] for one cycle and go to DROP.
REQ-017 In STATUS, status 2 SHALL increment retry_cnt and go to WAIT if retry_cnt<MAX_RETRY, otherwise pulse req_meta_ready[g] and go to DROP.
REQ-018 WAIT SHALL count RETRY_WAIT cycles and then return to META with the same grant and meta.
REQ-019 In DATA, the granted requester's data SHALL pass combinationally to m_axis_tx_data, with zero latency and req_data_ready[g] = m_axis_tx_data_TREADY; all other req_data_ready SHALL be 0.
REQ-020 DATA SHALL return to IDLE after a beat with TLAST=1 is accepted, increment sent_count, and set last_grant to g.
REQ-021 DROP SHALL hold req_data_ready[g]=1 and m_axis_tx_data_TVALID=0, leave after a TLAST beat, increment drop_count, and set last_grant to g.
REQ-022 retry_cnt SHALL clear on every new grant.
REQ-023 Counters SHALL wrap modulo 2^32.
REQ-024 A single-beat packet (TLAST on the first beat) SHALL complete DATA or DROP in one accepted cycle.
REQ-025 Requesters deasserting req_meta_valid before grant SHALL simply be skipped; after grant, the meta SHALL be latched internally.
REQ-026 Data beats offered before the granted DATA/DROP state SHALL not be accepted.

Reset
REQ-027 When aresetn=0 at a clk edge, the block SHALL set state=IDLE, last_grant=N_REQ-1, retry_cnt=0, sent_count=0, drop_count=0.
REQ-028 When aresetn=0 at a clk edge, every valid/ready output SHALL be 0 and metadata TDATA SHALL be 0.
REQ-029 Reset mid-packet SHALL abandon the packet with no further handshakes.
REQ-030 After reset, arbitration SHALL start at requester 0.

Structure
REQ-031 A shared package SHALL hold the state enumeration, the status code constants (OK=0, NOCONN=1, NOSPACE=2, ERR=3), and the metadata field offsets.
REQ-032 The round-robin grant logic SHALL be one sub-module, rr_arbiter (request vector and last grant in, one-hot grant and index out).
REQ-033 The total RTL SHALL be 120-400 lines.

Verification
REQ-034 Bench case: requesters 0 and 2 each request a 3-beat packet, status ok -> packet 0 then packet 2 on TX, sent_count=2, TLAST on beats 3 and 6.
REQ-035 Bench case: all 4 requesters request continuously for 8 packets -> grant order 0,1,2,3,0,1,2,3.
REQ-036 Bench case: status=1 for session 0x0005 with 4 beats -> no TX data, 4 beats consumed, drop_count=1, next requester served.
REQ-037 Bench case: status=2 twice then 0, RETRY_WAIT=4 -> 3 metadata issues at least 4 cycles apart, packet then sent.
REQ-038 Bench case: status=2 nine times with MAX_RETRY=8 -> 9 metadata issues, packet dropped, drop_count=1.
REQ-039 Bench case: TREADY toggling every cycle plus aresetn=0 on beat 2 -> all outputs 0 next cycle, counters 0, fresh grant to requester 0.
